// File: rtl/trp_seq.sv
// trp_seq: tile sequencer in front of the transpose FIFO (trp_fifo).
// Takes a BUFFD x BUFFD byte tile as BUFFD row beats, writes the rows into
// trp_fifo, issues column reads (8-bit or 32-bit mode) and re-streams the
// transposed beats through a 2-entry output buffer.
// Optional feature: define TRP_SEQ_PERF_EN to add the perf_stall counter port.
module trp_seq #(
  parameter int BUFFD = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         cfg_mode,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [BUFFD*8-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [BUFFD*8-1:0] m_data,
  output logic               m_last,
  output logic [1:0]         ff_mode,
  output logic               ff_init,
  output logic               ff_wreq,
  output logic [BUFFD*8-1:0] ff_wdata,
  output logic               ff_rreq,
  input  logic [BUFFD*8-1:0] ff_rdata,
  input  logic               ff_rvld
`ifdef TRP_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CW = $clog2(BUFFD);
  localparam logic [1:0] MODE_8  = 2'b01;
  localparam logic [1:0] MODE_32 = 2'b10;
  localparam logic [CW-1:0] LAST_ROW  = CW'(BUFFD - 1);
  localparam logic [CW-1:0] LAST_RD32 = CW'(BUFFD / 4 - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_WAIT} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      wcnt;
  logic [CW-1:0]      issued;
  logic [1:0]         mode_q;
  logic               rreq_q;       // read issued last cycle, data arrives now
  logic               rreq_last_q;  // that read was the final column of the tile
  logic [1:0]         occ;
  logic [BUFFD*8-1:0] buf_data [2];
  logic               buf_last [2];
  logic               mode_ok;
  logic               pop;
  logic               rd_last;
  logic [2:0]         credit_use;

  assign mode_ok    = (cfg_mode == MODE_8) || (cfg_mode == MODE_32);
  assign pop        = m_valid && m_ready;
  assign rd_last    = (issued == ((mode_q == MODE_8) ? LAST_ROW : LAST_RD32));
  // Entries that will occupy the buffer next cycle if nothing new is issued.
  assign credit_use = {1'b0, occ} + {2'b00, rreq_q} - {2'b00, pop};

  assign busy     = (state != S_IDLE);
  assign ff_mode  = mode_q;
  assign ff_wreq  = s_valid && s_ready;
  assign ff_wdata = s_data;
  assign m_valid  = (occ != 2'd0);
  assign m_data   = buf_data[0];
  assign m_last   = m_valid && buf_last[0];

  // State register.
  // NOTE: clocked state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and per-state control strobes.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    ff_init   = 1'b0;
    ff_rreq   = 1'b0;
    err       = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && mode_ok) begin
          ff_init   = 1'b1;
          state_nxt = S_FILL;
        end else if (start) begin
          err = 1'b1;
        end
      end
      S_FILL: begin
        s_ready = 1'b1;
        if (s_valid && (wcnt == LAST_ROW)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (credit_use < 3'd2) begin
          ff_rreq = 1'b1;
          if (rd_last) state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (pop && m_last) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Row/column counters, latched mode and read-in-flight tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt        <= '0;
      issued      <= '0;
      mode_q      <= 2'b00;
      rreq_q      <= 1'b0;
      rreq_last_q <= 1'b0;
    end else begin
      if (ff_init) begin
        mode_q <= cfg_mode;
        wcnt   <= '0;
        issued <= '0;
      end
      if (ff_wreq) wcnt <= wcnt + 1'b1;
      if (ff_rreq) issued <= rd_last ? '0 : issued + 1'b1;
      rreq_q      <= ff_rreq;
      rreq_last_q <= ff_rreq && rd_last;
    end
  end

  // Two-entry output buffer; entry 0 is the head presented on m_*.
  // NOTE: the storage is reset as well because m_data must read 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ         <= 2'd0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last[0] <= 1'b0;
      buf_last[1] <= 1'b0;
    end else begin
      case ({ff_rvld, pop})
        2'b10: begin
          buf_data[occ[0]] <= ff_rdata;
          buf_last[occ[0]] <= rreq_last_q;
          occ              <= occ + 2'd1;
        end
        2'b01: begin
          buf_data[0] <= buf_data[1];
          buf_last[0] <= buf_last[1];
          occ         <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            buf_data[0] <= buf_data[1];
            buf_last[0] <= buf_last[1];
            buf_data[1] <= ff_rdata;
            buf_last[1] <= rreq_last_q;
          end else begin
            buf_data[0] <= ff_rdata;
            buf_last[0] <= rreq_last_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Read credit guarantees a returning column always finds a free entry.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(ff_rvld && (occ == 2'd2)));

`ifdef TRP_SEQ_PERF_EN
  // Saturating count of cycles the consumer back-pressures a valid beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                    perf_stall <= '0;
    else if (ff_init)                                perf_stall <= '0;
    else if (m_valid && !m_ready && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
  end
`endif

endmodule

// File: tb/tb_trp_seq.sv
// tb_trp_seq: self-checking bench for trp_seq with BUFFD=8.
// A behavioural trp_fifo model answers reads; a monitor collects output beats
// and handshake statistics; scenario tasks compare against values derived
// from the tile contents and the transpose rules.
`timescale 1ns/1ps
module tb_trp_seq;

  localparam int BUFFD = 8;
  localparam int W     = BUFFD * 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   cfg_mode = 2'b00;
  logic         busy, done, err;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic         m_last;
  logic [1:0]   ff_mode;
  logic         ff_init, ff_wreq, ff_rreq;
  logic [W-1:0] ff_wdata;
  logic [W-1:0] ff_rdata;
  logic         ff_rvld;
`ifdef TRP_SEQ_PERF_EN
  logic [31:0]  perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  trp_seq #(.BUFFD(BUFFD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_mode(cfg_mode),
    .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .ff_mode(ff_mode), .ff_init(ff_init), .ff_wreq(ff_wreq), .ff_wdata(ff_wdata),
    .ff_rreq(ff_rreq), .ff_rdata(ff_rdata), .ff_rvld(ff_rvld)
`ifdef TRP_SEQ_PERF_EN
    , .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- trp_fifo behavioural model ----------------
  logic [7:0] fmem [BUFFD][BUFFD];
  int fw, fr;

  function automatic logic [W-1:0] fifo_col(input int k, input logic [1:0] md);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < BUFFD; i++)
      v[i*8 +: 8] = (md == 2'b01) ? fmem[i][k] : fmem[i/4][4*k + i%4];
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff_rvld  <= 1'b0;
      ff_rdata <= '0;
      fw       <= 0;
      fr       <= 0;
    end else begin
      ff_rvld <= ff_rreq;
      if (ff_init) begin
        fw <= 0;
        fr <= 0;
      end
      if (ff_wreq && fw < BUFFD) begin
        for (int j = 0; j < BUFFD; j++) fmem[fw][j] <= ff_wdata[j*8 +: 8];
        fw <= fw + 1;
      end
      if (ff_rreq) begin
        ff_rdata <= fifo_col(fr, ff_mode);
        fr       <= fr + 1;
      end
    end
  end

  // ---------------- monitor ----------------
  int mon_occ = 0, mon_inflight = 0, credit_viol = 0, early_rd = 0, wr_seen = 0;
  int done_cnt = 0, done_on_last = 0, stall_cnt = 0, init_cnt = 0, err_cnt = 0;
  int cyc = 0, first_pop = 0, last_pop = 0;
  bit pop;
  logic [W-1:0] beats [$];
  logic         lasts [$];

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      mon_occ      = 0;
      mon_inflight = 0;
    end else begin
      pop = m_valid && m_ready;
      if (ff_init) begin
        init_cnt++;
        wr_seen = 0; done_cnt = 0; done_on_last = 0; stall_cnt = 0;
        credit_viol = 0; early_rd = 0;
        beats.delete(); lasts.delete();
      end
      if (ff_rreq && (mon_occ + mon_inflight - int'(pop)) >= 2) credit_viol++;
      if (ff_rreq && wr_seen < BUFFD) early_rd++;
      if (ff_wreq) wr_seen++;
      if (m_valid && !m_ready) stall_cnt++;
      if (err) err_cnt++;
      if (pop) begin
        if (beats.size() == 0) first_pop = cyc;
        last_pop = cyc;
        beats.push_back(m_data);
        lasts.push_back(m_last);
      end
      if (done) begin
        done_cnt++;
        if (pop && m_last) done_on_last++;
      end
      mon_occ      = mon_occ + int'(ff_rvld) - int'(pop);
      mon_inflight = int'(ff_rreq);
    end
  end

  // ---------------- reference data ----------------
  logic [7:0] tile [BUFFD][BUFFD];

  function automatic logic [W-1:0] exp_beat(input int k, input logic [1:0] md);
    logic [W-1:0] v;
    int r, c;
    v = '0;
    for (int i = 0; i < BUFFD; i++) begin
      r = (md == 2'b01) ? i : i / 4;
      c = (md == 2'b01) ? k : 4 * k + i % 4;
      v[i*8 +: 8] = tile[r][c];
    end
    return v;
  endfunction

  function automatic logic [10:0] ctl_outs();
    return {busy, done, err, s_ready, m_valid, m_last, ff_mode, ff_init, ff_wreq, ff_rreq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; cfg_mode = 2'b00;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
  endtask

  task automatic start_tile(input logic [1:0] md, input bit rand_data, input string name);
    for (int r = 0; r < BUFFD; r++)
      for (int c = 0; c < BUFFD; c++)
        tile[r][c] = rand_data ? 8'($urandom) : 8'(r * BUFFD + c);
    tick();
    start = 1'b1; cfg_mode = md;
    @(negedge clk);
    total++;
    if (ff_init !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s start: ff_init=%0b err=%0b busy=%0b want 1 0 0", name, ff_init, err, busy);
    end
    tick();
    start = 1'b0; cfg_mode = 2'($urandom);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || ff_mode !== md) begin
      bad++;
      $display("FAIL %s fill_entry: busy=%0b s_ready=%0b ff_mode=%0d want 1 1 %0d",
               name, busy, s_ready, ff_mode, md);
    end
  endtask

  task automatic feed_rows(input int gap_pct);
    for (int r = 0; r < BUFFD; r++) begin
      if ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      s_valid = 1'b1;
      for (int c = 0; c < BUFFD; c++) s_data[c*8 +: 8] = tile[r][c];
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic run_tile(input logic [1:0] md, input bit rand_data, input int gap_pct,
                          input int rdy_pct, input bit poke, input bit chk_thru, input string name);
    int nrd, init0, err0, budget;
    nrd = (md == 2'b01) ? BUFFD : BUFFD / 4;
    start_tile(md, rand_data, name);
    init0 = init_cnt;
    err0  = err_cnt;
    feed_rows(gap_pct);
    budget = 0;
    while (done_cnt == 0 && budget < 400) begin
      m_ready = ($urandom_range(99) < rdy_pct);
      if (poke) begin
        start    = (budget < 2);
        cfg_mode = (budget == 0) ? 2'b11 : ((md == 2'b01) ? 2'b10 : 2'b01);
      end
      tick();
      budget++;
    end
    start = 1'b0; m_ready = 1'b0;
    if (budget >= 400) begin
      total++; bad++;
      $display("FAIL %s timeout: no done after %0d cycles", name, budget);
    end
    @(negedge clk);
    total++;
    if (done_cnt !== 1 || done_on_last !== 1) begin
      bad++;
      $display("FAIL %s done: pulses=%0d on_last=%0d want 1 1", name, done_cnt, done_on_last);
    end
    total++;
    if (beats.size() !== nrd) begin
      bad++;
      $display("FAIL %s beat_count: got %0d want %0d", name, beats.size(), nrd);
    end
    for (int k = 0; k < nrd && k < beats.size(); k++) begin
      total++;
      if (beats[k] !== exp_beat(k, md) || lasts[k] !== (k == nrd - 1)) begin
        bad++;
        $display("FAIL %s beat%0d: data=%h last=%0b want %h %0b",
                 name, k, beats[k], lasts[k], exp_beat(k, md), (k == nrd - 1));
      end
    end
    total++;
    if (wr_seen !== BUFFD || early_rd !== 0 || credit_viol !== 0) begin
      bad++;
      $display("FAIL %s fifo_ctl: writes=%0d early_reads=%0d credit_viol=%0d want %0d 0 0",
               name, wr_seen, early_rd, credit_viol, BUFFD);
    end
    total++;
    if (busy !== 1'b0 || init_cnt - init0 !== 0 || err_cnt - err0 !== 0) begin
      bad++;
      $display("FAIL %s end_state: busy=%0b extra_init=%0d extra_err=%0d want 0 0 0",
               name, busy, init_cnt - init0, err_cnt - err0);
    end
    if (chk_thru) begin
      total++;
      if (last_pop - first_pop !== nrd - 1) begin
        bad++;
        $display("FAIL %s throughput: span=%0d cycles want %0d", name, last_pop - first_pop, nrd - 1);
      end
    end
`ifdef TRP_SEQ_PERF_EN
    total++;
    if (perf_stall !== 32'(stall_cnt)) begin
      bad++;
      $display("FAIL %s perf_stall: got %0d want %0d", name, perf_stall, stall_cnt);
    end
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    total++;
    if (ctl_outs() !== 11'd0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 0", ctl_outs());
    end
    total++;
    if (m_data !== '0 || ff_wdata !== '0) begin
      bad++;
      $display("FAIL reset_data: m_data=%h ff_wdata=%h want 0", m_data, ff_wdata);
    end
`ifdef TRP_SEQ_PERF_EN
    total++;
    if (perf_stall !== 32'd0) begin
      bad++;
      $display("FAIL reset_perf: got %0d want 0", perf_stall);
    end
`endif
  endtask

  task automatic test_mode8();
    logic [W-1:0] v;
    run_tile(2'b01, 1'b0, 0, 100, 1'b0, 1'b1, "mode8");
    for (int k = 0; k < BUFFD && k < beats.size(); k++) begin
      for (int i = 0; i < BUFFD; i++) v[i*8 +: 8] = 8'(i * 8 + k);
      total++;
      if (beats[k] !== v) begin
        bad++;
        $display("FAIL mode8_const beat%0d: got %h want %h", k, beats[k], v);
      end
    end
  endtask

  task automatic test_mode32();
    logic [W-1:0] v;
    run_tile(2'b10, 1'b0, 0, 100, 1'b0, 1'b1, "mode32");
    for (int k = 0; k < BUFFD / 4 && k < beats.size(); k++) begin
      for (int i = 0; i < BUFFD; i++) v[i*8 +: 8] = 8'((i / 4) * 8 + 4 * k + i % 4);
      total++;
      if (beats[k] !== v) begin
        bad++;
        $display("FAIL mode32_const beat%0d: got %h want %h", k, beats[k], v);
      end
    end
  endtask

  task automatic test_random_backpressure();
    for (int t = 0; t < 6; t++)
      run_tile(($urandom_range(1) != 0) ? 2'b01 : 2'b10, 1'b1, 0, 50, 1'b0, 1'b0, "rand_bp");
  endtask

  task automatic test_fill_gaps();
    for (int t = 0; t < 3; t++)
      run_tile(($urandom_range(1) != 0) ? 2'b01 : 2'b10, 1'b1, 60, 70, 1'b0, 1'b0, "fill_gaps");
  endtask

  task automatic test_illegal_mode();
    logic [1:0] bad_modes [2];
    bad_modes[0] = 2'b00;
    bad_modes[1] = 2'b11;
    for (int n = 0; n < 2; n++) begin
      tick();
      start = 1'b1; cfg_mode = bad_modes[n];
      @(negedge clk);
      total++;
      if (err !== 1'b1 || ff_init !== 1'b0) begin
        bad++;
        $display("FAIL illegal_err mode=%0d: err=%0b ff_init=%0b want 1 0", bad_modes[n], err, ff_init);
      end
      tick();
      start = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || err !== 1'b0 || s_ready !== 1'b0) begin
        bad++;
        $display("FAIL illegal_after mode=%0d: busy=%0b err=%0b s_ready=%0b want 0 0 0",
                 bad_modes[n], busy, err, s_ready);
      end
    end
  endtask

  task automatic test_start_during_drain();
    run_tile(2'b01, 1'b1, 0, 80, 1'b1, 1'b0, "start_in_drain");
    run_tile(2'b10, 1'b1, 0, 80, 1'b1, 1'b0, "start_in_drain32");
  endtask

  task automatic test_reset_mid_drain();
    start_tile(2'b01, 1'b1, "rst_mid");
    feed_rows(0);
    m_ready = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_pre: m_valid=%0b busy=%0b want 1 1", m_valid, busy);
    end
    tick();
    reset_n = 1'b0; s_data = '0;
    @(negedge clk);
    total++;
    if (ctl_outs() !== 11'd0 || m_data !== '0 || ff_wdata !== '0) begin
      bad++;
      $display("FAIL rst_mid_outs: ctl=%b m_data=%h want 0", ctl_outs(), m_data);
    end
    total++;
    if (done_cnt !== 0) begin
      bad++;
      $display("FAIL rst_mid_done: pulses=%0d want 0", done_cnt);
    end
    tick();
    reset_n = 1'b1;
    tick();
    run_tile(2'b10, 1'b1, 20, 60, 1'b0, 1'b0, "after_rst");
  endtask

  initial begin
    do_reset();
    test_reset();
    test_mode8();
    test_mode32();
    test_random_backpressure();
    test_fill_gaps();
    test_illegal_mode();
    test_start_during_drain();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
